// File: rtl/fpnew_sdotp_rr_arbiter.sv
// Round-robin issue arbiter plus in-order response router that shares one sdotp unit between NumReq requesters.
// Optional perf counters are built when FPNEW_SDOTP_ARB_PERF_EN is defined.
module fpnew_sdotp_rr_arbiter #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned LaneWidth      = 64,
  parameter int unsigned TagWidth       = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned OpWidth        = 4,
  parameter int unsigned FmtWidth       = 3,
  parameter int unsigned RndWidth       = 3,
  parameter int unsigned StatusWidth    = 5
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NumReq-1:0]                      req_valid_i,
  output logic [NumReq-1:0]                      req_ready_o,
  input  logic [NumReq-1:0][2:0][LaneWidth-1:0]  req_operands_i,
  input  logic [NumReq-1:0][OpWidth-1:0]         req_op_i,
  input  logic [NumReq-1:0]                      req_op_mod_i,
  input  logic [NumReq-1:0][FmtWidth-1:0]        req_src_fmt_i,
  input  logic [NumReq-1:0][FmtWidth-1:0]        req_dst_fmt_i,
  input  logic [NumReq-1:0][RndWidth-1:0]        req_rnd_mode_i,
  input  logic [NumReq-1:0][TagWidth-1:0]        req_tag_i,
  output logic [2:0][LaneWidth-1:0]              unit_operands_o,
  output logic [OpWidth-1:0]                     unit_op_o,
  output logic                                   unit_op_mod_o,
  output logic [FmtWidth-1:0]                    unit_src_fmt_o,
  output logic [FmtWidth-1:0]                    unit_dst_fmt_o,
  output logic [RndWidth-1:0]                    unit_rnd_mode_o,
  output logic [TagWidth-1:0]                    unit_tag_o,
  output logic                                   unit_valid_o,
  input  logic                                   unit_ready_i,
  output logic                                   unit_flush_o,
  input  logic [LaneWidth-1:0]                   unit_result_i,
  input  logic [StatusWidth-1:0]                 unit_status_i,
  input  logic                                   unit_ext_bit_i,
  input  logic [TagWidth-1:0]                    unit_tag_i,
  input  logic                                   unit_out_valid_i,
  output logic                                   unit_out_ready_o,
  input  logic                                   unit_busy_i,
  output logic [NumReq-1:0]                      rsp_valid_o,
  input  logic [NumReq-1:0]                      rsp_ready_i,
  output logic [LaneWidth-1:0]                   rsp_result_o,
  output logic [StatusWidth-1:0]                 rsp_status_o,
  output logic                                   rsp_ext_bit_o,
  output logic [TagWidth-1:0]                    rsp_tag_o,
  input  logic                                   flush_i,
  output logic                                   busy_o,
  output logic [NumReq-1:0][31:0]                perf_grants_o,
  output logic [31:0]                            perf_stall_o
);

  localparam int unsigned IdWidth  = $clog2(NumReq);
  localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

  logic [IdWidth-1:0]                        rr_ptr_q, rr_ptr_d;
  logic [CntWidth-1:0]                       cnt_q, cnt_d;
  logic [PtrWidth-1:0]                       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic                                      lock_q, lock_d;
  logic [IdWidth-1:0]                        lock_idx_q, lock_idx_d;
  logic [MaxOutstanding-1:0][IdWidth-1:0]    id_mem_q, id_mem_d;

  logic               gnt_valid;
  logic [IdWidth-1:0] gnt_idx;
  logic [IdWidth-1:0] cand;
  logic               full, empty, issue, pop;
  logic [IdWidth-1:0] head;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(MaxOutstanding - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  assign full  = (cnt_q == CntWidth'(MaxOutstanding));
  assign empty = (cnt_q == '0);
  assign head  = id_mem_q[rd_ptr_q];

  // Grant selection: a locked grant is held until its handshake, otherwise search from rr_ptr.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    if (lock_q) begin
      gnt_valid = req_valid_i[lock_idx_q];
      gnt_idx   = lock_idx_q;
    end else begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        cand = IdWidth'((32'(rr_ptr_q) + i) % NumReq);
        if (!gnt_valid && req_valid_i[cand]) begin
          gnt_valid = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
    if (rst_i || flush_i || full) gnt_valid = 1'b0;
  end

  assign issue = gnt_valid & unit_ready_i;

  always_comb begin
    req_ready_o          = '0;
    req_ready_o[gnt_idx] = issue;
  end

  assign unit_valid_o    = gnt_valid;
  assign unit_operands_o = req_operands_i[gnt_idx];
  assign unit_op_o       = req_op_i[gnt_idx];
  assign unit_op_mod_o   = req_op_mod_i[gnt_idx];
  assign unit_src_fmt_o  = req_src_fmt_i[gnt_idx];
  assign unit_dst_fmt_o  = req_dst_fmt_i[gnt_idx];
  assign unit_rnd_mode_o = req_rnd_mode_i[gnt_idx];
  assign unit_tag_o      = req_tag_i[gnt_idx];
  assign unit_flush_o    = flush_i;

  // Response routing to the FIFO head; stray or flushed responses are accepted and dropped.
  always_comb begin
    rsp_valid_o      = '0;
    unit_out_ready_o = 1'b0;
    if (!rst_i) begin
      if (flush_i || empty) begin
        unit_out_ready_o = 1'b1;
      end else begin
        unit_out_ready_o  = rsp_ready_i[head];
        rsp_valid_o[head] = unit_out_valid_i;
      end
    end
  end

  assign pop           = unit_out_valid_i & unit_out_ready_o & ~empty & ~flush_i & ~rst_i;
  assign rsp_result_o  = unit_result_i;
  assign rsp_status_o  = unit_status_i;
  assign rsp_ext_bit_o = unit_ext_bit_i;
  assign rsp_tag_o     = unit_tag_i;
  assign busy_o        = (cnt_q != '0) | unit_busy_i;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    id_mem_d   = id_mem_q;
    if (flush_i) begin
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      lock_d   = 1'b0;
    end else begin
      if (issue) begin
        id_mem_d[wr_ptr_q] = gnt_idx;
        wr_ptr_d           = ptr_inc(wr_ptr_q);
        rr_ptr_d           = (gnt_idx == IdWidth'(NumReq - 1)) ? '0 : gnt_idx + IdWidth'(1);
        lock_d             = 1'b0;
      end else if (gnt_valid) begin
        lock_d     = 1'b1;
        lock_idx_d = gnt_idx;
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({issue, pop})
        2'b10:   cnt_d = cnt_q + CntWidth'(1);
        2'b01:   cnt_d = cnt_q - CntWidth'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      id_mem_q   <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      id_mem_q   <= id_mem_d;
    end
  end

`ifdef FPNEW_SDOTP_ARB_PERF_EN
  logic [NumReq-1:0][31:0] perf_grants_q, perf_grants_d;
  logic [31:0]             perf_stall_q, perf_stall_d;

  // Saturating counters, cleared only by reset.
  always_comb begin
    perf_grants_d = perf_grants_q;
    perf_stall_d  = perf_stall_q;
    if (issue && (perf_grants_q[gnt_idx] != '1))
      perf_grants_d[gnt_idx] = perf_grants_q[gnt_idx] + 32'd1;
    if ((|req_valid_i) && full && (perf_stall_q != '1))
      perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_grants_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_grants_q <= perf_grants_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_grants_o = perf_grants_q;
  assign perf_stall_o  = perf_stall_q;
`else
  assign perf_grants_o = '0;
  assign perf_stall_o  = '0;
`endif

  a_rsp_needs_inflight: assert property (@(posedge clk_i) disable iff (rst_i)
    !(unit_out_valid_i && empty && !flush_i));

endmodule

// File: tb/tb_fpnew_sdotp_rr_arbiter.sv
// Self-checking bench for fpnew_sdotp_rr_arbiter: directed vector table followed by
// randomized traffic against a queue-based reference model.
module tb_fpnew_sdotp_rr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned LW = 64;
  localparam int unsigned TW = 4;
  localparam int unsigned MO = 4;

  logic                      clk, rst;
  logic [N-1:0]              req_valid, req_ready;
  logic [N-1:0][2:0][LW-1:0] req_ops;
  logic [N-1:0][3:0]         req_op;
  logic [N-1:0]              req_op_mod;
  logic [N-1:0][2:0]         req_src, req_dst, req_rnd;
  logic [N-1:0][TW-1:0]      req_tag;
  logic [2:0][LW-1:0]        unit_ops;
  logic [3:0]                unit_op;
  logic                      unit_op_mod;
  logic [2:0]                unit_src, unit_dst, unit_rnd;
  logic [TW-1:0]             unit_tag_o;
  logic                      unit_valid, unit_ready, unit_flush;
  logic [LW-1:0]             unit_result;
  logic [4:0]                unit_status;
  logic                      unit_ext;
  logic [TW-1:0]             unit_tag_i;
  logic                      unit_out_valid, unit_out_ready, unit_busy;
  logic [N-1:0]              rsp_valid, rsp_ready;
  logic [LW-1:0]             rsp_result;
  logic [4:0]                rsp_status;
  logic                      rsp_ext;
  logic [TW-1:0]             rsp_tag;
  logic                      flush, busy;
  logic [N-1:0][31:0]        perf_grants;
  logic [31:0]               perf_stall;

  fpnew_sdotp_rr_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_operands_i(req_ops),
    .req_op_i(req_op), .req_op_mod_i(req_op_mod), .req_src_fmt_i(req_src),
    .req_dst_fmt_i(req_dst), .req_rnd_mode_i(req_rnd), .req_tag_i(req_tag),
    .unit_operands_o(unit_ops), .unit_op_o(unit_op), .unit_op_mod_o(unit_op_mod),
    .unit_src_fmt_o(unit_src), .unit_dst_fmt_o(unit_dst), .unit_rnd_mode_o(unit_rnd),
    .unit_tag_o(unit_tag_o), .unit_valid_o(unit_valid), .unit_ready_i(unit_ready),
    .unit_flush_o(unit_flush), .unit_result_i(unit_result), .unit_status_i(unit_status),
    .unit_ext_bit_i(unit_ext), .unit_tag_i(unit_tag_i), .unit_out_valid_i(unit_out_valid),
    .unit_out_ready_o(unit_out_ready), .unit_busy_i(unit_busy),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
    .rsp_status_o(rsp_status), .rsp_ext_bit_o(rsp_ext), .rsp_tag_o(rsp_tag),
    .flush_i(flush), .busy_o(busy), .perf_grants_o(perf_grants), .perf_stall_o(perf_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: ID queue, round-robin pointer, held grant, perf tallies.
  int q[$];
  int rr = 0;
  bit locked = 1'b0;
  int lidx = 0;
  int m_grants[N];
  int m_stall = 0;

  typedef struct {
    int rst, flush, valid, uready, outv, rspr, ubusy;
    int e_uv, e_g, e_rr, e_rv, e_or, e_busy;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int model_grant();
    if (rst || flush || q.size() >= MO) return -1;
    if (locked) return req_valid[lidx] ? lidx : -1;
    for (int k = 0; k < N; k++)
      if (req_valid[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  task automatic model_update(input int g);
    if (rst) begin
      q.delete(); rr = 0; locked = 1'b0; m_stall = 0;
      for (int i = 0; i < N; i++) m_grants[i] = 0;
    end else begin
      if ((|req_valid) && q.size() == MO) m_stall++;
      if (flush) begin
        q.delete(); locked = 1'b0;
      end else begin
        if (q.size() > 0 && unit_out_valid && rsp_ready[q[0]]) void'(q.pop_front());
        if (g >= 0 && unit_ready) begin
          q.push_back(g); rr = (g + 1) % N; locked = 1'b0; m_grants[g]++;
        end else if (g >= 0) begin
          locked = 1'b1; lidx = g;
        end
      end
    end
  endtask

  initial begin
    int g;
    int exp_rv, exp_or;
    rst = 1'b1; flush = 1'b0; req_valid = '0; req_ops = '0; req_op = '0; req_op_mod = '0;
    req_src = '0; req_dst = '0; req_rnd = '0; unit_ready = 1'b0; unit_result = '0;
    unit_status = '0; unit_ext = 1'b0; unit_tag_i = '0; unit_out_valid = 1'b0;
    unit_busy = 1'b0; rsp_ready = '0;
    for (int i = 0; i < N; i++) begin
      req_tag[i] = TW'(i + 5);
      req_ops[i][0] = LW'(64'h1000 + i);
    end

    // rst, flush, valid, uready, outv, rspr, ubusy | uv, g, req_ready, rsp_valid, out_ready, busy
    tbl.push_back(vec_t'{0,0,'hF,1,0,0,0, 1, 0,1,0,1,0});
    tbl.push_back(vec_t'{0,0,'hF,1,0,0,0, 1, 1,2,0,0,1});
    tbl.push_back(vec_t'{0,0,'hF,1,0,0,0, 1, 2,4,0,0,1});
    tbl.push_back(vec_t'{0,0,'hF,1,0,0,0, 1, 3,8,0,0,1});
    tbl.push_back(vec_t'{0,0,'hF,1,1,1,0, 0,-1,0,1,1,1});
    tbl.push_back(vec_t'{0,0,'hF,1,0,0,0, 1, 0,1,0,0,1});
    tbl.push_back(vec_t'{0,0,  0,1,1,0,0, 0,-1,0,2,0,1});
    tbl.push_back(vec_t'{0,0,  0,1,1,2,0, 0,-1,0,2,1,1});
    tbl.push_back(vec_t'{0,1,'hF,1,1,'hF,0, 0,-1,0,0,1,1});
    tbl.push_back(vec_t'{0,0,  8,1,0,0,1, 1, 3,8,0,1,1});
    tbl.push_back(vec_t'{0,0,  4,0,0,0,0, 1, 2,0,0,0,1});
    tbl.push_back(vec_t'{0,0,  5,0,0,0,0, 1, 2,0,0,0,1});
    tbl.push_back(vec_t'{0,0,  5,0,0,0,0, 1, 2,0,0,0,1});
    tbl.push_back(vec_t'{0,0,  5,1,0,0,0, 1, 2,4,0,0,1});
    tbl.push_back(vec_t'{0,0,  1,1,0,0,0, 1, 0,1,0,0,1});
    tbl.push_back(vec_t'{0,0,  2,1,1,7,0, 1, 1,2,8,0,1});
    tbl.push_back(vec_t'{0,0,  6,1,1,0,0, 0,-1,0,8,0,1});
    tbl.push_back(vec_t'{0,0,  6,1,1,8,0, 0,-1,0,8,1,1});
    tbl.push_back(vec_t'{0,0,  6,1,0,0,0, 1, 2,4,0,0,1});
    tbl.push_back(vec_t'{1,0,'hF,1,1,'hF,0, 0,-1,0,0,0,1});
    tbl.push_back(vec_t'{0,0,  0,1,0,0,0, 0,-1,0,0,1,0});
    tbl.push_back(vec_t'{0,0,'hA,1,0,0,0, 1, 1,2,0,1,0});
    tbl.push_back(vec_t'{1,0,  0,1,0,0,0, 0,-1,0,0,0,1});
    tbl.push_back(vec_t'{0,0,  2,1,0,0,0, 1, 1,2,0,1,0});
    tbl.push_back(vec_t'{0,0,  8,1,0,0,0, 1, 3,8,0,0,1});
    tbl.push_back(vec_t'{0,0,  2,1,0,0,0, 1, 1,2,0,0,1});
    tbl.push_back(vec_t'{0,0,  0,1,1,'hF,0, 0,-1,0,2,1,1});
    tbl.push_back(vec_t'{0,0,  0,1,1,'hF,0, 0,-1,0,8,1,1});
    tbl.push_back(vec_t'{0,0,  0,1,1,'hF,0, 0,-1,0,2,1,1});
    tbl.push_back(vec_t'{0,0,  0,1,0,0,0, 0,-1,0,0,1,0});

    repeat (2) @(negedge clk);
    #1;
    chk("reset_unit_valid", 192'(unit_valid), 192'(0));
    chk("reset_req_ready", 192'(req_ready), 192'(0));
    chk("reset_rsp_valid", 192'(rsp_valid), 192'(0));
    chk("reset_out_ready", 192'(unit_out_ready), 192'(0));
    chk("reset_busy", 192'(busy), 192'(0));
    model_update(-1);
    @(negedge clk);

    foreach (tbl[r]) begin
      cyc++;
      rst = 1'(tbl[r].rst); flush = 1'(tbl[r].flush); req_valid = 4'(tbl[r].valid);
      unit_ready = 1'(tbl[r].uready); unit_out_valid = 1'(tbl[r].outv);
      rsp_ready = 4'(tbl[r].rspr); unit_busy = 1'(tbl[r].ubusy); unit_tag_i = TW'(r);
      #1;
      chk("vec_unit_valid", 192'(unit_valid), 192'(tbl[r].e_uv));
      chk("vec_req_ready", 192'(req_ready), 192'(tbl[r].e_rr));
      chk("vec_rsp_valid", 192'(rsp_valid), 192'(tbl[r].e_rv));
      chk("vec_out_ready", 192'(unit_out_ready), 192'(tbl[r].e_or));
      chk("vec_busy", 192'(busy), 192'(tbl[r].e_busy));
      chk("vec_rsp_tag", 192'(rsp_tag), 192'(r % 16));
      if (tbl[r].e_uv != 0) chk("vec_unit_tag", 192'(unit_tag_o), 192'(tbl[r].e_g + 5));
      g = model_grant();
      model_update(g);
      @(negedge clk);
    end

    for (int c = 0; c < 600; c++) begin
      cyc++;
      rst   = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 29) == 0);
      for (int i = 0; i < N; i++) begin
        if (!(locked && i == lidx)) begin
          req_valid[i]  = ($urandom_range(0, 99) < 60);
          req_tag[i]    = TW'($urandom);
          req_op[i]     = 4'($urandom);
          req_op_mod[i] = 1'($urandom);
          req_src[i]    = 3'($urandom);
          req_dst[i]    = 3'($urandom);
          req_rnd[i]    = 3'($urandom);
          for (int w = 0; w < 3; w++) req_ops[i][w] = {$urandom, $urandom};
        end
        rsp_ready[i] = ($urandom_range(0, 99) < 70);
      end
      unit_ready     = ($urandom_range(0, 99) < 60);
      unit_out_valid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      unit_busy      = ($urandom_range(0, 99) < 20);
      unit_result    = {$urandom, $urandom};
      unit_status    = 5'($urandom);
      unit_ext       = 1'($urandom);
      unit_tag_i     = TW'($urandom);
      #1;
      g = model_grant();
      exp_rv = (!rst && !flush && q.size() > 0 && unit_out_valid) ? (1 << q[0]) : 0;
      if (rst) exp_or = 0;
      else if (flush || q.size() == 0) exp_or = 1;
      else exp_or = int'(rsp_ready[q[0]]);
      chk("rnd_unit_valid", 192'(unit_valid), 192'(g >= 0));
      chk("rnd_req_ready", 192'(req_ready), 192'((g >= 0 && unit_ready) ? (1 << g) : 0));
      chk("rnd_rsp_valid", 192'(rsp_valid), 192'(exp_rv));
      chk("rnd_out_ready", 192'(unit_out_ready), 192'(exp_or));
      chk("rnd_busy", 192'(busy), 192'((q.size() != 0) || unit_busy));
      chk("rnd_flush", 192'(unit_flush), 192'(flush));
      chk("rnd_rsp_payload", {59'(0), rsp_ext, rsp_status, rsp_tag, rsp_result, 64'(0)},
          {59'(0), unit_ext, unit_status, unit_tag_i, unit_result, 64'(0)});
      if (g >= 0) begin
        chk("rnd_unit_tag", 192'(unit_tag_o), 192'(req_tag[g]));
        chk("rnd_unit_ops", 192'(unit_ops), 192'(req_ops[g]));
        chk("rnd_unit_ctrl", 192'({unit_op, unit_op_mod, unit_src, unit_dst, unit_rnd}),
            192'({req_op[g], req_op_mod[g], req_src[g], req_dst[g], req_rnd[g]}));
      end
      model_update(g);
      @(negedge clk);
    end

    rst = 1'b0; flush = 1'b0; req_valid = '0; unit_out_valid = 1'b0;
    #1;
`ifdef FPNEW_SDOTP_ARB_PERF_EN
    for (int i = 0; i < N; i++) chk("perf_grants", 192'(perf_grants[i]), 192'(m_grants[i]));
    chk("perf_stall", 192'(perf_stall), 192'(m_stall));
`else
    chk("perf_grants_zero", 192'(perf_grants), 192'(0));
    chk("perf_stall_zero", 192'(perf_stall), 192'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
